e_md_issue: RTL and testbench

//  D->E issue stage for the multiply/divide unit. Latches the decoded MD instruction and operands

---
 rtl/e_md_issue.sv | 172 +++++++++++++++++
 tb/tb_e_md_issue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_md_issue.sv
// ---------------------------------------------------------------------------
// e_md_issue
//
// D->E issue stage for the multiply/divide unit. Captures the decoded MD
// instruction and its operands from D, presents op/D1/D2/Start to the E-stage
// MDU for exactly one cycle per instruction, and tracks whether a mult/div is
// still running. D is stalled whenever an MD-class instruction would collide
// with a running mult/div. When nothing new is issuing, e_op carries IDLE_OP,
// which the MDU treats as "no operation".
//
// Optional feature macro: MD_TIMEOUT_EN
//   defined   : watchdog counts WAIT cycles; if the MDU is still busy after
//               TIMEOUT_CYCLES cycles, err_timeout is set (sticky) and the
//               FSM is forced back to IDLE.
//   undefined : no watchdog, err_timeout is tied to 0.
//
// Ports
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   d_valid      in   1   D-stage instruction valid
//   d_is_md      in   1   D instruction is MD-class
//   d_md_op      in   4   0 mult,1 multu,2 div,3 divu,4 mfhi,5 mflo,6 mthi,7 mtlo
//   d_rs_val     in   32  forwarded rs value
//   d_rt_val     in   32  forwarded rt value
//   stall_ext    in   1   stall from other hazards; freezes the E register
//   flush        in   1   load a bubble into E on the next edge
//   mdu_busy     in   1   MDU busy
//   e_start      out  1   one-cycle start pulse for mult/div
//   e_op         out  4   op to MDU (IDLE_OP when nothing issues)
//   e_d1, e_d2   out  32  registered rs/rt operands
//   e_valid      out  1   E holds a valid MD instruction
//   d_stall      out  1   combinational stall request to D/F
//   err_timeout  out  1   sticky watchdog flag
// ---------------------------------------------------------------------------
module e_md_issue #(
  parameter logic [3:0] IDLE_OP        = 4'b1111,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic        d_is_md,
  input  logic [3:0]  d_md_op,
  input  logic [31:0] d_rs_val,
  input  logic [31:0] d_rt_val,
  input  logic        stall_ext,
  input  logic        flush,
  input  logic        mdu_busy,
  output logic        e_start,
  output logic [3:0]  e_op,
  output logic [31:0] e_d1,
  output logic [31:0] e_d2,
  output logic        e_valid,
  output logic        d_stall,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  op_q;
  logic        issued;
  logic        presenting;
  logic        long_op;
  logic        timeout_hit;

  // An instruction is presented to the MDU only in the first cycle it sits
  // in E; "issued" suppresses re-presentation while stall_ext holds it.
  assign presenting = e_valid & ~issued;
  assign long_op    = (op_q[3:2] == 2'b00);
  assign e_op       = presenting ? op_q : IDLE_OP;
  assign e_start    = presenting & long_op;

  // mf/mt must also wait: HI/LO are not final until the mult/div completes.
  // The e_start term covers the cycle before the FSM leaves IDLE.
  assign d_stall = d_valid & d_is_md & ((state != S_IDLE) | e_start);

  // E register. Priority: reset > flush > stall_ext > d_stall > load.
  // Under stall_ext the fields are frozen but a presented instruction is
  // marked issued so it is never handed to the MDU a second time.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid <= 1'b0;
      op_q    <= IDLE_OP;
      e_d1    <= 32'd0;
      e_d2    <= 32'd0;
      issued  <= 1'b0;
    end else if (flush) begin
      e_valid <= 1'b0;
      issued  <= 1'b0;
    end else if (stall_ext) begin
      issued  <= issued | e_valid;
    end else if (d_stall) begin
      e_valid <= 1'b0;
      issued  <= 1'b0;
    end else begin
      e_valid <= d_valid & d_is_md;
      op_q    <= d_md_op;
      e_d1    <= d_rs_val;
      e_d2    <= d_rt_val;
      issued  <= 1'b0;
    end
  end

`ifdef MD_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT) & mdu_busy & (wait_cnt == TIMEOUT_LAST);

  // Counter restarts on the way into WAIT so it measures WAIT cycles only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= 5'd0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= 5'd0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 5'd1;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State register. The FSM follows e_start regardless of stall_ext/flush,
  // because the MDU has already accepted the operation at that point.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ISSUE is a single cycle in which the MDU has not yet raised busy, so
  // busy is only examined once in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (e_start) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (timeout_hit || !mdu_busy) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_e_md_issue.sv
// ---------------------------------------------------------------------------
// tb_e_md_issue
//
// Directed bench for e_md_issue. A small behavioural MDU sits beside the DUT:
// on e_start it computes HI/LO from e_d1/e_d2, stays quiet for the ISSUE
// cycle, then raises busy for 5 (mult) or 10 (div) cycles. mthi/mtlo write
// HI/LO when presented. forceBusy pins busy high for the watchdog scenario.
//
// With that MDU, a mult holds an MD instruction in D for 8 cycles
// (e_start cycle + ISSUE + 5 busy WAIT cycles + 1 idle WAIT cycle) and a
// div for 13 cycles.
// ---------------------------------------------------------------------------
module tb_e_md_issue;

  localparam logic [3:0] IDLE_OP = 4'b1111;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic        d_is_md;
  logic [3:0]  d_md_op;
  logic [31:0] d_rs_val;
  logic [31:0] d_rt_val;
  logic        stall_ext;
  logic        flush;
  logic        mdu_busy;
  logic        e_start;
  logic [3:0]  e_op;
  logic [31:0] e_d1;
  logic [31:0] e_d2;
  logic        e_valid;
  logic        d_stall;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  int stallCycles;

  e_md_issue dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_is_md     (d_is_md),
    .d_md_op     (d_md_op),
    .d_rs_val    (d_rs_val),
    .d_rt_val    (d_rt_val),
    .stall_ext   (stall_ext),
    .flush       (flush),
    .mdu_busy    (mdu_busy),
    .e_start     (e_start),
    .e_op        (e_op),
    .e_d1        (e_d1),
    .e_d2        (e_d2),
    .e_valid     (e_valid),
    .d_stall     (d_stall),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU model
  logic        forceBusy;
  logic        pending;
  logic [4:0]  pendLen;
  logic [4:0]  busyCnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic signed [63:0] sprod;
  logic [63:0] uprod;

  assign sprod    = $signed({{32{e_d1[31]}}, e_d1}) * $signed({{32{e_d2[31]}}, e_d2});
  assign uprod    = {32'd0, e_d1} * {32'd0, e_d2};
  assign mdu_busy = forceBusy | (busyCnt != 5'd0);

  always @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pendLen <= 5'd0;
      busyCnt <= 5'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      if (e_start) begin
        pending <= 1'b1;
        pendLen <= e_op[1] ? 5'd10 : 5'd5;
        case (e_op)
          4'd0: begin hi <= sprod[63:32]; lo <= sprod[31:0]; end
          4'd1: begin hi <= uprod[63:32]; lo <= uprod[31:0]; end
          4'd2: if (e_d2 != 0) begin
                  hi <= $signed(e_d1) % $signed(e_d2);
                  lo <= $signed(e_d1) / $signed(e_d2);
                end
          default: if (e_d2 != 0) begin
                  hi <= e_d1 % e_d2;
                  lo <= e_d1 / e_d2;
                end
        endcase
      end else if (pending) begin
        pending <= 1'b0;
        busyCnt <= pendLen;
      end else if (busyCnt != 5'd0) begin
        busyCnt <= busyCnt - 5'd1;
      end
      if (e_op == 4'd6) hi <= e_d1;
      if (e_op == 4'd7) lo <= e_d1;
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic md, input logic [3:0] op,
                               input logic [31:0] rs, input logic [31:0] rt);
    d_valid  = v;
    d_is_md  = md;
    d_md_op  = op;
    d_rs_val = rs;
    d_rt_val = rt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps while d_stall is high, bounded so a stuck stall cannot hang the run.
  task automatic countStall(output int n);
    n = 0;
    while (d_stall && n < 40) begin
      n++;
      stepCycle();
    end
  endtask

  initial begin
    reset     = 1'b1;
    stall_ext = 1'b0;
    flush     = 1'b0;
    forceBusy = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_e_op",    32'(e_op),        32'(IDLE_OP));
      checkOutput("rst_e_start", 32'(e_start),     32'd0);
      checkOutput("rst_d_stall", 32'(d_stall),     32'd0);
      checkOutput("rst_err",     32'(err_timeout), 32'd0);
    end
    checkOutput("rst_e_valid", 32'(e_valid), 32'd0);
    checkOutput("rst_e_d1",    e_d1,         32'd0);
    reset = 1'b0;
    stepCycle();

    // 2: mult 7 * -3, then mflo
    $display("[TB] mult then mflo");
    applyStimulus(1'b1, 1'b1, 4'd0, 32'd7, 32'hFFFF_FFFD);
    stepCycle();
    checkOutput("mul_e_op",    32'(e_op),    32'd0);
    checkOutput("mul_e_start", 32'(e_start), 32'd1);
    checkOutput("mul_e_d1",    e_d1,         32'd7);
    checkOutput("mul_e_d2",    e_d2,         32'hFFFF_FFFD);
    applyStimulus(1'b1, 1'b1, 4'd5, 32'd0, 32'd0);
    checkOutput("mflo_stall_now", 32'(d_stall), 32'd1);
    stepCycle();
    checkOutput("mul_start_once", 32'(e_start), 32'd0);
    checkOutput("mul_bubble",     32'(e_valid), 32'd0);
    countStall(stallCycles);
    checkOutput("mflo_stall_cycles", 32'(stallCycles), 32'd7);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("mflo_e_op",    32'(e_op),    32'd5);
    checkOutput("mflo_e_start", 32'(e_start), 32'd0);
    checkOutput("mflo_lo",      lo,           32'hFFFF_FFEB);
    checkOutput("mul_hi",       hi,           32'hFFFF_FFFF);
    stepCycle();
    checkOutput("mflo_one_cycle", 32'(e_op), 32'(IDLE_OP));

    // 3: div 100 / 7, then mthi 5
    $display("[TB] div then mthi");
    applyStimulus(1'b1, 1'b1, 4'd2, 32'd100, 32'd7);
    stepCycle();
    checkOutput("div_e_op",    32'(e_op),    32'd2);
    checkOutput("div_e_start", 32'(e_start), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'd6, 32'd5, 32'd0);
    stepCycle();
    countStall(stallCycles);
    checkOutput("mthi_stall_cycles", 32'(stallCycles), 32'd12);
    checkOutput("div_lo", lo, 32'd14);
    checkOutput("div_hi", hi, 32'd2);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("mthi_e_op", 32'(e_op), 32'd6);
    checkOutput("mthi_e_d1", e_d1,      32'd5);
    stepCycle();
    checkOutput("mthi_one_cycle", 32'(e_op), 32'(IDLE_OP));
    checkOutput("mthi_hi",        hi,        32'd5);

    // 4: mult held by stall_ext for four cycles
    $display("[TB] mult under stall_ext");
    applyStimulus(1'b1, 1'b1, 4'd0, 32'd3, 32'd4);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    stall_ext = 1'b1;
    checkOutput("hold_first_op",    32'(e_op),    32'd0);
    checkOutput("hold_first_start", 32'(e_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("hold_e_op",    32'(e_op),    32'(IDLE_OP));
      checkOutput("hold_e_start", 32'(e_start), 32'd0);
      checkOutput("hold_e_valid", 32'(e_valid), 32'd1);
      checkOutput("hold_e_d1",    e_d1,         32'd3);
    end
    stall_ext = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("nonmd_no_stall", 32'(d_stall), 32'd0);
    stepCycle();
    checkOutput("nonmd_not_valid", 32'(e_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("hold_lo", lo, 32'd12);

    // 5: flush with mthi in D, stall_ext also high
    $display("[TB] flush beats stall_ext");
    applyStimulus(1'b1, 1'b1, 4'd6, 32'd9, 32'd0);
    flush     = 1'b1;
    stall_ext = 1'b1;
    checkOutput("flush_idle_no_stall", 32'(d_stall), 32'd0);
    stepCycle();
    flush     = 1'b0;
    stall_ext = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("flush_e_valid", 32'(e_valid), 32'd0);
    checkOutput("flush_e_op",    32'(e_op),    32'(IDLE_OP));
    stepCycle();
    checkOutput("flush_hi_kept", hi, 32'd0);

    // 6: MDU stuck busy after a mult
    $display("[TB] stuck busy");
    applyStimulus(1'b1, 1'b1, 4'd0, 32'd2, 32'd2);
    stepCycle();
    forceBusy = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd5, 32'd0, 32'd0);
`ifdef MD_TIMEOUT_EN
    for (int i = 0; i < 17; i++) stepCycle();
    checkOutput("wd_not_yet",       32'(err_timeout), 32'd0);
    checkOutput("wd_stall_before",  32'(d_stall),     32'd1);
    stepCycle();
    checkOutput("wd_fired",         32'(err_timeout), 32'd1);
    checkOutput("wd_stall_dropped", 32'(d_stall),     32'd0);
    forceBusy = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("wd_sticky", 32'(err_timeout), 32'd1);
`else
    for (int i = 0; i < 20; i++) stepCycle();
    checkOutput("stuck_stall", 32'(d_stall),     32'd1);
    checkOutput("stuck_err",   32'(err_timeout), 32'd0);
    forceBusy = 1'b0;
    countStall(stallCycles);
    checkOutput("stuck_released", 32'(stallCycles < 40), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    stepCycle();
`endif

    // Reset in the middle of a mult
    $display("[TB] reset mid-operation");
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("rst2_err", 32'(err_timeout), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'd1, 32'd6, 32'd6);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd5, 32'd0, 32'd0);
    checkOutput("rst_mid_e_valid", 32'(e_valid), 32'd0);
    checkOutput("rst_mid_idle",    32'(d_stall), 32'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkOutput("rst_mid_mflo", 32'(e_op), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
